// File: rtl/cursor_ctrl.sv
// Button conditioning and cursor positioning: synchronizes and debounces four
// active-low direction buttons, then turns presses into clamped, auto-repeating cursor steps.
module cursor_ctrl #(
    parameter int SIZE          = 8,
    parameter int STEP          = 4,
    parameter int W_RES         = 640,
    parameter int H_RES         = 480,
    parameter int DEBOUNCE      = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 2000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        up_but,
    input  logic        down_but,
    input  logic        left_but,
    input  logic        right_but,
    output logic [10:0] cursor_x,
    output logic [10:0] cursor_y,
    output logic        moved,
    output logic [1:0]  active_dir
);

    localparam int DCW = $clog2(DEBOUNCE + 1);
    localparam int RCW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [11:0] X_MAX  = 12'(W_RES - SIZE);
    localparam logic [11:0] Y_MAX  = 12'(H_RES - SIZE);
    localparam logic [11:0] STEP12 = 12'(STEP);
    localparam logic [10:0] X_INIT = 11'(W_RES / 2 - SIZE / 2);
    localparam logic [10:0] Y_INIT = 11'(H_RES / 2 - SIZE / 2);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    // Button vectors are indexed by direction code.
    logic [3:0] pin_n;
    logic [3:0] sync1_q, sync2_q, raw;
    assign pin_n = {right_but, left_but, down_but, up_but};
    assign raw   = ~sync2_q;

    // NOTE: synchronizer flops reset to 1 so a button held through reset is
    // seen as a fresh press and pays the full sync plus debounce latency.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= pin_n;
            sync2_q <= sync1_q;
        end
    end

    logic [3:0]     deb_q, deb_d;
    logic [DCW-1:0] db_cnt_q [4];
    logic [DCW-1:0] db_cnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (raw[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DCW'(DEBOUNCE - 1)) deb_d[i] = ~deb_q[i];
                else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    state_t         state_q, state_d;
    dir_t           dir_q, dir_d;
    logic [RCW-1:0] rep_q, rep_d;
    logic [10:0]    x_q, x_d, y_q, y_d;
    logic           moved_q, moved_d;
    logic           do_step;
    logic [11:0]    x_ext, y_ext, nx, ny;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rep_d   = rep_q;
        do_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if      (deb_q[DIR_UP])    dir_d = DIR_UP;
                else if (deb_q[DIR_DOWN])  dir_d = DIR_DOWN;
                else if (deb_q[DIR_LEFT])  dir_d = DIR_LEFT;
                else if (deb_q[DIR_RIGHT]) dir_d = DIR_RIGHT;
                if (|deb_q) begin
                    do_step = 1'b1;
                    rep_d   = RCW'(REPEAT_DELAY - 1);
                    state_d = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!deb_q[dir_q]) begin
                    state_d = IDLE;
                end else if (rep_q == '0) begin
                    do_step = 1'b1;
                    rep_d   = RCW'(REPEAT_PERIOD - 1);
                    state_d = REPEAT;
                end else begin
                    rep_d = rep_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // 12-bit intermediates keep the down/right sum from wrapping before the clamp.
        x_ext = {1'b0, x_q};
        y_ext = {1'b0, y_q};
        nx    = x_ext;
        ny    = y_ext;
        unique case (dir_d)
            DIR_UP:    ny = (y_ext < STEP12) ? 12'd0 : y_ext - STEP12;
            DIR_DOWN:  ny = (y_ext + STEP12 > Y_MAX) ? Y_MAX : y_ext + STEP12;
            DIR_LEFT:  nx = (x_ext < STEP12) ? 12'd0 : x_ext - STEP12;
            DIR_RIGHT: nx = (x_ext + STEP12 > X_MAX) ? X_MAX : x_ext + STEP12;
            default: ;
        endcase

        x_d     = do_step ? nx[10:0] : x_q;
        y_d     = do_step ? ny[10:0] : y_q;
        moved_d = do_step && ((nx != x_ext) || (ny != y_ext));
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            rep_q   <= '0;
            x_q     <= X_INIT;
            y_q     <= Y_INIT;
            moved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rep_q   <= rep_d;
            x_q     <= x_d;
            y_q     <= y_d;
            moved_q <= moved_d;
        end
    end

    assign cursor_x   = x_q;
    assign cursor_y   = y_q;
    assign moved      = moved_q;
    assign active_dir = dir_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl with short debounce/repeat timing; a second
// instance with STEP=5 exercises the clamp at y=0.
`timescale 1ns/1ps
module tb_cursor_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        up_n, down_n, left_n, right_n, up5_n;
    logic [10:0] cx, cy, cx5, cy5;
    logic        mv, mv5;
    logic [1:0]  dir, dir5;

    int n_tests = 0;
    int n_fail  = 0;

    cursor_ctrl #(.SIZE(8), .STEP(4), .W_RES(640), .H_RES(480),
                  .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .CLOCK_50(clk), .reset(rst_n),
        .up_but(up_n), .down_but(down_n), .left_but(left_n), .right_but(right_n),
        .cursor_x(cx), .cursor_y(cy), .moved(mv), .active_dir(dir)
    );

    cursor_ctrl #(.SIZE(8), .STEP(5), .W_RES(640), .H_RES(480),
                  .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut5 (
        .CLOCK_50(clk), .reset(rst_n),
        .up_but(up5_n), .down_but(1'b1), .left_but(1'b1), .right_but(1'b1),
        .cursor_x(cx5), .cursor_y(cy5), .moved(mv5), .active_dir(dir5)
    );

    // Edge e counts from the first edge that samples the newly driven pin.
    function automatic bit is_step(int e);
        return (e == DB + 2) || (e >= DB + 2 + RD && (e - (DB + 2 + RD)) % RP == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        up_n = 1'b1; down_n = 1'b1; left_n = 1'b1; right_n = 1'b1; up5_n = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (cx !== 11'd316) begin n_fail++; $display("FAIL reset_x: got %0d expected 316", cx); end
        n_tests++; if (cy !== 11'd236) begin n_fail++; $display("FAIL reset_y: got %0d expected 236", cy); end
        n_tests++; if (mv !== 1'b0) begin n_fail++; $display("FAIL reset_moved: got %0b expected 0", mv); end
        n_tests++; if (dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir: got %0d expected 0", dir); end
        n_tests++; if (cy5 !== 11'd236 || cx5 !== 11'd316) begin n_fail++; $display("FAIL reset_pos5: got %0d/%0d expected 316/236", cx5, cy5); end
        for (int c = 0; c < 100; c++) begin
            tick();
            n_tests++;
            if (cx !== 11'd316 || cy !== 11'd236 || mv !== 1'b0) begin
                n_fail++; $display("FAIL idle_stable cycle %0d: got x=%0d y=%0d moved=%0b expected 316/236/0", c, cx, cy, mv);
            end
        end
    endtask

    task automatic test_glitch_and_repeat();
        int ex;
        do_reset();
        right_n = 1'b0;
        repeat (3) tick();
        right_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_tests++;
            if (cx !== 11'd316 || mv !== 1'b0) begin
                n_fail++; $display("FAIL glitch cycle %0d: got x=%0d moved=%0b expected 316/0", c, cx, mv);
            end
        end
        right_n = 1'b0;
        ex = 316;
        for (int e = 0; e <= 22; e++) begin
            tick();
            if (is_step(e)) ex += 4;
            n_tests++;
            if (cx !== 11'(ex) || mv !== is_step(e)) begin
                n_fail++; $display("FAIL repeat edge %0d: got x=%0d moved=%0b expected %0d/%0b", e, cx, mv, ex, is_step(e));
            end
        end
        right_n = 1'b1;
    endtask

    task automatic test_clamp_zero();
        int ey;
        int moves;
        bit chg;
        do_reset();
        up5_n = 1'b0;
        ey = 236;
        moves = 0;
        for (int e = 0; e <= 170; e++) begin
            tick();
            chg = is_step(e) && (ey > 0);
            if (is_step(e)) ey = (ey < 5) ? 0 : ey - 5;
            if (mv5) moves++;
            n_tests++;
            if (cy5 !== 11'(ey) || mv5 !== chg) begin
                n_fail++; $display("FAIL clamp_zero edge %0d: got y=%0d moved=%0b expected %0d/%0b", e, cy5, mv5, ey, chg);
            end
        end
        n_tests++; if (moves != 48) begin n_fail++; $display("FAIL clamp_zero_count: got %0d expected 48", moves); end
        n_tests++; if (cy5 !== 11'd0) begin n_fail++; $display("FAIL clamp_zero_final: got %0d expected 0", cy5); end
        up5_n = 1'b1;
    endtask

    task automatic test_clamp_max();
        int ev;
        int moves;
        bit chg;
        do_reset();
        down_n = 1'b0;
        ev = 236;
        moves = 0;
        for (int e = 0; e <= 210; e++) begin
            tick();
            chg = is_step(e) && (ev < 472);
            if (is_step(e)) ev = (ev + 4 > 472) ? 472 : ev + 4;
            if (mv) moves++;
            n_tests++;
            if (cy !== 11'(ev) || mv !== chg || cx !== 11'd316) begin
                n_fail++; $display("FAIL clamp_down edge %0d: got x=%0d y=%0d moved=%0b expected 316/%0d/%0b", e, cx, cy, mv, ev, chg);
            end
        end
        n_tests++; if (moves != 59) begin n_fail++; $display("FAIL clamp_down_count: got %0d expected 59", moves); end
        down_n = 1'b1;

        do_reset();
        right_n = 1'b0;
        ev = 316;
        moves = 0;
        for (int e = 0; e <= 260; e++) begin
            tick();
            chg = is_step(e) && (ev < 632);
            if (is_step(e)) ev = (ev + 4 > 632) ? 632 : ev + 4;
            if (mv) moves++;
            n_tests++;
            if (cx !== 11'(ev) || mv !== chg || cy !== 11'd236) begin
                n_fail++; $display("FAIL clamp_right edge %0d: got x=%0d y=%0d moved=%0b expected %0d/236/%0b", e, cx, cy, mv, ev, chg);
            end
        end
        n_tests++; if (moves != 79) begin n_fail++; $display("FAIL clamp_right_count: got %0d expected 79", moves); end
        right_n = 1'b1;
    endtask

    task automatic test_priority();
        int ex, ey;
        bit em;
        do_reset();
        up_n = 1'b0;
        right_n = 1'b0;
        for (int e = 0; e <= 17; e++) begin
            if (e == 8) up_n = 1'b1;
            tick();
            ey = (e >= 6) ? 232 : 236;
            ex = (e >= 15) ? 320 : 316;
            em = (e == 6) || (e == 15);
            n_tests++;
            if (cx !== 11'(ex) || cy !== 11'(ey) || mv !== em) begin
                n_fail++; $display("FAIL priority edge %0d: got x=%0d y=%0d moved=%0b expected %0d/%0d/%0b", e, cx, cy, mv, ex, ey, em);
            end
            if (e == 6) begin
                n_tests++; if (dir !== 2'd0) begin n_fail++; $display("FAIL priority_dir_up: got %0d expected 0", dir); end
            end
            if (e == 15) begin
                n_tests++; if (dir !== 2'd3) begin n_fail++; $display("FAIL priority_dir_right: got %0d expected 3", dir); end
            end
        end
        right_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        int ex;
        do_reset();
        left_n = 1'b0;
        repeat (20) tick();
        n_tests++;
        if (cx !== 11'd304 || mv !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got x=%0d moved=%0b expected 304/1", cx, mv);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cx !== 11'd316 || cy !== 11'd236 || mv !== 1'b0 || dir !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: got x=%0d y=%0d moved=%0b dir=%0d expected 316/236/0/0", cx, cy, mv, dir);
        end
        #1 rst_n = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            ex = (e >= 6) ? 312 : 316;
            n_tests++;
            if (cx !== 11'(ex) || mv !== (e == 6)) begin
                n_fail++; $display("FAIL post_reset edge %0d: got x=%0d moved=%0b expected %0d/%0b", e, cx, mv, ex, (e == 6));
            end
        end
        left_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        up_n = 1'b1; down_n = 1'b1; left_n = 1'b1; right_n = 1'b1; up5_n = 1'b1;
        test_reset();
        test_glitch_and_repeat();
        test_clamp_zero();
        test_clamp_max();
        test_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
